instruction_fetch_unit: RTL

//  Fetch stage that sits directly upstream of instruction_mem: owns the program counter, drives

---
 rtl/instruction_fetch_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction_address, and holds fetched words in an IF/ID register handed to decode over valid/ready.
// Optional `define FETCH_COUNT_EN adds a fetch_count output that counts transfers.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instruction_address,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] out_instr,
`ifdef FETCH_COUNT_EN
  output logic [31:0] fetch_count,
`endif
  output logic        misaligned_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        load;

  assign pc_plus4            = pc + 32'd4;
  assign misaligned          = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign load                = !out_valid || out_ready;
  assign instruction_address = pc;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: defaulting state_next before the case keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (misaligned) state_next = FAULT;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // FAULT is terminal until reset, so the sticky flag is exactly "in FAULT".
  always_comb begin
    misaligned_fault = (state == FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      out_valid    <= 1'b0;
      out_pc       <= 32'h0;
      out_pc_plus4 <= 32'h0;
      out_instr    <= NOP_INSTR;
    end else if (state == FETCH) begin
      if (misaligned || redirect_valid || flush) begin
        // Any of these empties IF/ID; only an aligned redirect moves the PC.
        out_valid <= 1'b0;
        out_instr <= NOP_INSTR;
        if (redirect_valid && !misaligned) pc <= redirect_target;
      end else if (load) begin
        out_valid    <= 1'b1;
        out_pc       <= pc;
        out_pc_plus4 <= pc_plus4;
        out_instr    <= instruction;
        pc           <= pc_plus4;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        fetch_count <= 32'h0;
    else if (state == FETCH && out_valid && out_ready) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule
